motion_estimator_core: RTL and testbench

Full-search block-matching motion estimator for video compression. It compares a 16x16 reference block against every 16x16 candidate inside a 31x31 search window and reports the best displacement and its sum-of-absolute-differences (SAD). It drives external combinational-read memories: one reference memory and a dual-read-port search memory. It sits between the frame buffers and the encoder's motion-vector stage.

---
 rtl/motion_estimator_core.sv | 182 ++++++++++++++++++
 tb/tb_motion_estimator_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/motion_estimator_core.sv
// Full-search 16x16 block matcher over a 31x31 window, scoring two candidates per pass.
// Optional macro ME_DONE_EN adds a one-cycle done pulse when the results update.
module motion_estimator_core (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] dataRef,
    input  logic [7:0] dataSearch1,
    input  logic [7:0] dataSearch2,
    output logic [7:0] addressR,
    output logic [9:0] addressS1,
    output logic [9:0] addressS2,
    output logic [7:0] bestDist,
    output logic [3:0] motionX,
    output logic [3:0] motionY
`ifdef ME_DONE_EN
    ,
    output logic       done
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;   // {pair[6:0], pixel[7:0]}: dy=[14:11], dxA=[10:8], r=[7:4], c=[3:0]
    logic [15:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [15:0] best_q, best_d;
    logic [3:0]  dx_q, dx_d, dy_q, dy_d;
    logic [7:0]  addr_r_q, addr_r_d;
    logic [9:0]  addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
    logic [7:0]  best_dist_q, best_dist_d;
    logic [3:0]  mx_q, mx_d, my_q, my_d;
    logic [15:0] sum_a, sum_b;
`ifdef ME_DONE_EN
    logic        done_q, done_d;
`endif

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        abs_diff = (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [9:0] search_addr(input logic [3:0] row0, input logic [3:0] r,
                                               input logic [3:0] col0, input logic [3:0] c);
        search_addr = ({6'd0, row0} + {6'd0, r}) * 10'd31 + {6'd0, col0} + {6'd0, c};
    endfunction

    // Next-state, accumulate/compare and address generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        best_d      = best_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        best_dist_d = best_dist_q;
        mx_d        = mx_q;
        my_d        = my_q;
`ifdef ME_DONE_EN
        done_d      = 1'b0;
`endif
        sum_a = acc_a_q + {8'd0, abs_diff(dataRef, dataSearch1)};
        sum_b = acc_b_q + {8'd0, abs_diff(dataRef, dataSearch2)};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 15'd0;
                    acc_a_d = 16'd0;
                    acc_b_d = 16'd0;
                    best_d  = 16'hFFFF;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 15'd1;
                if (cnt_q[7:0] == 8'hFF) begin
                    acc_a_d = 16'd0;
                    acc_b_d = 16'd0;
                    // A is tested before B, and only strict improvement replaces best.
                    if (sum_a < best_q) begin
                        best_d = sum_a;
                        dx_d   = {1'b0, cnt_q[10:8]};
                        dy_d   = cnt_q[14:11];
                    end else begin
                        best_d = best_q;
                    end
                    if (sum_b < best_d) begin
                        best_d = sum_b;
                        dx_d   = {1'b1, cnt_q[10:8]};
                        dy_d   = cnt_q[14:11];
                    end else begin
                        best_d = best_d;
                    end
                end else begin
                    acc_a_d = sum_a;
                    acc_b_d = sum_b;
                end
                if (cnt_q == 15'h7FFF) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                best_dist_d = (best_q > 16'd255) ? 8'hFF : best_q[7:0];
                mx_d        = dx_q;
                my_d        = dy_q;
`ifdef ME_DONE_EN
                done_d      = 1'b1;
`endif
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Addresses are registered, so they are derived from the next counter value.
        if (state_d == RUN) begin
            addr_r_d  = cnt_d[7:0];
            addr_s1_d = search_addr(cnt_d[14:11], cnt_d[7:4], {1'b0, cnt_d[10:8]}, cnt_d[3:0]);
            addr_s2_d = search_addr(cnt_d[14:11], cnt_d[7:4], {1'b1, cnt_d[10:8]}, cnt_d[3:0]);
        end else begin
            addr_r_d  = 8'd0;
            addr_s1_d = 10'd0;
            addr_s2_d = 10'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 15'd0;
            acc_a_q     <= 16'd0;
            acc_b_q     <= 16'd0;
            best_q      <= 16'd0;
            dx_q        <= 4'd0;
            dy_q        <= 4'd0;
            addr_r_q    <= 8'd0;
            addr_s1_q   <= 10'd0;
            addr_s2_q   <= 10'd0;
            best_dist_q <= 8'd0;
            mx_q        <= 4'd0;
            my_q        <= 4'd0;
`ifdef ME_DONE_EN
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            best_q      <= best_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            addr_r_q    <= addr_r_d;
            addr_s1_q   <= addr_s1_d;
            addr_s2_q   <= addr_s2_d;
            best_dist_q <= best_dist_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
`ifdef ME_DONE_EN
            done_q      <= done_d;
`endif
        end
    end

    assign addressR  = addr_r_q;
    assign addressS1 = addr_s1_q;
    assign addressS2 = addr_s2_q;
    assign bestDist  = best_dist_q;
    assign motionX   = mx_q;
    assign motionY   = my_q;
`ifdef ME_DONE_EN
    assign done      = done_q;
`endif

endmodule

// File: tb/tb_motion_estimator_core.sv
// Directed bench for motion_estimator_core with behavioural reference and search memories.
module tb_motion_estimator_core;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] dataRef, dataSearch1, dataSearch2;
    logic [7:0] addressR;
    logic [9:0] addressS1, addressS2;
    logic [7:0] bestDist;
    logic [3:0] motionX, motionY;
`ifdef ME_DONE_EN
    logic       done;
    int         done_cnt = 0;
`endif

    logic [7:0] ref_mem  [0:255];
    logic [7:0] srch_mem [0:960];

    int tests_run    = 0;
    int tests_failed = 0;

    motion_estimator_core dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dataRef     (dataRef),
        .dataSearch1 (dataSearch1),
        .dataSearch2 (dataSearch2),
        .addressR    (addressR),
        .addressS1   (addressS1),
        .addressS2   (addressS2),
        .bestDist    (bestDist),
        .motionX     (motionX),
        .motionY     (motionY)
`ifdef ME_DONE_EN
        ,
        .done        (done)
`endif
    );

    assign dataRef     = ref_mem[addressR];
    assign dataSearch1 = srch_mem[addressS1];
    assign dataSearch2 = srch_mem[addressS2];

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef ME_DONE_EN
    always @(posedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end
`endif

    task automatic load_flat(input logic [7:0] ref_val, input logic [7:0] srch_val);
        for (int i = 0; i < 256; i++) ref_mem[i] = ref_val;
        for (int i = 0; i < 961; i++) srch_mem[i] = srch_val;
    endtask

    // Pseudo-random block copied into the window at row 15, col 12 over a 0x80 background.
    task automatic load_block();
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k * k * 7 + k * 13 + 5);
        for (int i = 0; i < 961; i++) srch_mem[i] = 8'h80;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                srch_mem[(15 + r) * 31 + 12 + c] = ref_mem[r * 16 + c];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++; if (addressR !== 8'd0) begin tests_failed++; $display("FAIL reset_addressR got %0d expected 0", addressR); end
        tests_run++; if (addressS1 !== 10'd0) begin tests_failed++; $display("FAIL reset_addressS1 got %0d expected 0", addressS1); end
        tests_run++; if (addressS2 !== 10'd0) begin tests_failed++; $display("FAIL reset_addressS2 got %0d expected 0", addressS2); end
        tests_run++; if (bestDist !== 8'd0) begin tests_failed++; $display("FAIL reset_bestDist got %0d expected 0", bestDist); end
        tests_run++; if (motionX !== 4'd0) begin tests_failed++; $display("FAIL reset_motionX got %0d expected 0", motionX); end
        tests_run++; if (motionY !== 4'd0) begin tests_failed++; $display("FAIL reset_motionY got %0d expected 0", motionY); end
`ifdef ME_DONE_EN
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0d expected 0", done); end
`endif
        reset = 1'b0;
        repeat (4) @(negedge clock);
        tests_run++; if (addressR !== 8'd0) begin tests_failed++; $display("FAIL idle_addressR got %0d expected 0", addressR); end
        tests_run++; if (addressS1 !== 10'd0) begin tests_failed++; $display("FAIL idle_addressS1 got %0d expected 0", addressS1); end
        tests_run++; if (addressS2 !== 10'd0) begin tests_failed++; $display("FAIL idle_addressS2 got %0d expected 0", addressS2); end
    endtask

    // Cycle 4999: pair 19 (dy=2, dxA=3), pixel 135 (r=8, c=7) -> S1=320, S2=328.
    task automatic test_abort();
        load_block();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (4999) @(negedge clock);
        tests_run++; if (addressR !== 8'd135) begin tests_failed++; $display("FAIL mid_addressR got %0d expected 135", addressR); end
        tests_run++; if (addressS1 !== 10'd320) begin tests_failed++; $display("FAIL mid_addressS1 got %0d expected 320", addressS1); end
        tests_run++; if (addressS2 !== 10'd328) begin tests_failed++; $display("FAIL mid_addressS2 got %0d expected 328", addressS2); end
        reset = 1'b1;
        #1;
        tests_run++; if (addressR !== 8'd0) begin tests_failed++; $display("FAIL abort_addressR got %0d expected 0", addressR); end
        tests_run++; if (addressS1 !== 10'd0) begin tests_failed++; $display("FAIL abort_addressS1 got %0d expected 0", addressS1); end
        tests_run++; if (addressS2 !== 10'd0) begin tests_failed++; $display("FAIL abort_addressS2 got %0d expected 0", addressS2); end
        tests_run++; if (bestDist !== 8'd0) begin tests_failed++; $display("FAIL abort_bestDist got %0d expected 0", bestDist); end
        @(negedge clock) reset = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++; if (addressS2 !== 10'd0) begin tests_failed++; $display("FAIL abort_idle_addressS2 got %0d expected 0", addressS2); end
        tests_run++; if (motionX !== 4'd0) begin tests_failed++; $display("FAIL abort_motionX got %0d expected 0", motionX); end
`ifdef ME_DONE_EN
        tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL abort_done_count got %0d expected 0", done_cnt); end
`endif
    endtask

    // Ref 0xFF vs search 0x00: every SAD is 65280, so the first candidate (0,0) wins and distance saturates.
    task automatic test_saturation();
        load_flat(8'hFF, 8'h00);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        tests_run++; if (addressR !== 8'd0) begin tests_failed++; $display("FAIL first_addressR got %0d expected 0", addressR); end
        tests_run++; if (addressS1 !== 10'd0) begin tests_failed++; $display("FAIL first_addressS1 got %0d expected 0", addressS1); end
        tests_run++; if (addressS2 !== 10'd8) begin tests_failed++; $display("FAIL first_addressS2 got %0d expected 8", addressS2); end
        repeat (999) @(negedge clock);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (31767) @(negedge clock);
        tests_run++; if (addressR !== 8'd255) begin tests_failed++; $display("FAIL last_addressR got %0d expected 255", addressR); end
        tests_run++; if (addressS1 !== 10'd952) begin tests_failed++; $display("FAIL last_addressS1 got %0d expected 952", addressS1); end
        tests_run++; if (addressS2 !== 10'd960) begin tests_failed++; $display("FAIL last_addressS2 got %0d expected 960", addressS2); end
        @(negedge clock);
        tests_run++; if (addressR !== 8'd0) begin tests_failed++; $display("FAIL done_addressR got %0d expected 0", addressR); end
        tests_run++; if (addressS1 !== 10'd0) begin tests_failed++; $display("FAIL done_addressS1 got %0d expected 0", addressS1); end
        tests_run++; if (addressS2 !== 10'd0) begin tests_failed++; $display("FAIL done_addressS2 got %0d expected 0", addressS2); end
        load_block();
    endtask

    // Start is raised in the idle cycle right after DONE; search 1 results checked at edge 32770.
    task automatic test_back_to_back();
        @(negedge clock);
`ifdef ME_DONE_EN
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_pulse got %0d expected 1", done); end
`endif
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        tests_run++; if (bestDist !== 8'd255) begin tests_failed++; $display("FAIL sat_bestDist got %0d expected 255", bestDist); end
        tests_run++; if (motionX !== 4'd0) begin tests_failed++; $display("FAIL sat_motionX got %0d expected 0", motionX); end
        tests_run++; if (motionY !== 4'd0) begin tests_failed++; $display("FAIL sat_motionY got %0d expected 0", motionY); end
        tests_run++; if (addressR !== 8'd0) begin tests_failed++; $display("FAIL b2b_addressR got %0d expected 0", addressR); end
        tests_run++; if (addressS2 !== 10'd8) begin tests_failed++; $display("FAIL b2b_addressS2 got %0d expected 8", addressS2); end
`ifdef ME_DONE_EN
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL done_width got %0d expected 0", done); end
`endif
    endtask

    task automatic test_block_match();
        repeat (32770) @(negedge clock);
        tests_run++; if (bestDist !== 8'd0) begin tests_failed++; $display("FAIL match_bestDist got %0d expected 0", bestDist); end
        tests_run++; if (motionX !== 4'd12) begin tests_failed++; $display("FAIL match_motionX got %0d expected 12", motionX); end
        tests_run++; if (motionY !== 4'd15) begin tests_failed++; $display("FAIL match_motionY got %0d expected 15", motionY); end
        tests_run++; if (addressS1 !== 10'd0) begin tests_failed++; $display("FAIL match_idle_addressS1 got %0d expected 0", addressS1); end
`ifdef ME_DONE_EN
        tests_run++; if (done_cnt !== 2) begin tests_failed++; $display("FAIL done_count got %0d expected 2", done_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_abort();
        test_saturation();
        test_back_to_back();
        test_block_match();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
